// File: rtl/if_id_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ifq_pkg
// Purpose : Shared sizes and the entry type for the IF/ID instruction queue.
// Rev     : 1.0
// ============================================================================
package ifq_pkg;

  localparam int IFQ_DEPTH = 4;
  localparam int IFQ_AW    = 64;
  localparam int IFQ_IW    = 32;

  typedef struct packed {
    logic [IFQ_AW-1:0] pc;
    logic [IFQ_IW-1:0] instr;
  } ifq_entry_t;

  function automatic int ifq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : ifq_if
// Purpose : Fetch-side and decode-side handshake bundle of the IF/ID queue.
// Rev     : 1.0
// ============================================================================
interface ifq_if
  import ifq_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = IFQ_AW,
  parameter int IW    = IFQ_IW
);

  logic [AW-1:0]               imem_addr_F;
  logic [IW-1:0]               instr_F;
  logic                        valid_F;
  logic                        ready_F;
  logic                        flush;
  logic [AW-1:0]               pc_D;
  logic [IW-1:0]               instr_D;
  logic                        valid_D;
  logic                        ready_D;
  logic [ifq_cnt_w(DEPTH)-1:0] count;

  // Queue side
  modport slave (
    input  imem_addr_F, instr_F, valid_F, flush, ready_D,
    output ready_F, pc_D, instr_D, valid_D, count
  );

  // Fetch/decode side
  modport master (
    output imem_addr_F, instr_F, valid_F, flush, ready_D,
    input  ready_F, pc_D, instr_D, valid_D, count
  );

endinterface
`default_nettype wire

// File: rtl/if_id_queue_mem.sv
`default_nettype none
// ============================================================================
// Module  : ifq_mem
// Purpose : Entry storage: one sync write port, one async read port, async clear.
// Rev     : 1.0
// ============================================================================
module ifq_mem
  import ifq_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       i_we,
  input  wire logic [PW-1:0] i_waddr,
  input  wire ifq_entry_t i_wdata,
  input  wire logic [PW-1:0] i_raddr,
  output ifq_entry_t      o_rdata
);

  ifq_entry_t r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module  : if_id_queue
// Purpose : In-order instruction queue between fetch and decode, flushed on a
//           taken branch. Optional empty-queue bypass under IFQ_BYPASS_EN.
// Rev     : 1.0
// ============================================================================
module if_id_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = IFQ_AW,
  parameter int IW    = IFQ_IW
) (
  input  wire logic clk,
  input  wire logic reset,
  ifq_if.slave      bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic       w_full;
  logic       w_empty;
  logic       w_bypass;
  logic       w_push;
  logic       w_pop;
  ifq_entry_t w_wdata;
  ifq_entry_t w_rdata;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_empty && bus.valid_F && !bus.flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed entry taken by decode in the same cycle is never stored.
  assign w_push = bus.valid_F && !w_full && !bus.flush && !(w_bypass && bus.ready_D);
  assign w_pop  = !w_empty && bus.ready_D && !bus.flush;

  assign w_wdata.pc    = bus.imem_addr_F;
  assign w_wdata.instr = bus.instr_F;

  ifq_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage may hold stale data when empty, so the head is gated by occupancy.
  assign bus.ready_F = !w_full;
  assign bus.count   = r_count;
  assign bus.valid_D = !w_empty || w_bypass;
  assign bus.pc_D    = !w_empty ? AW'(w_rdata.pc) :
                       (w_bypass ? bus.imem_addr_F : AW'(0));
  assign bus.instr_D = !w_empty ? IW'(w_rdata.instr) :
                       (w_bypass ? bus.instr_F : IW'(0));

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_id_queue
// Purpose : Self-checking bench for if_id_queue against a queue-based model.
// Rev     : 1.0
// ============================================================================
module tb_if_id_queue;
  import ifq_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 64;
  localparam int IW    = 32;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ifq_if #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check head/flags, clock, then update model.
  task automatic step(input bit vf, input logic [63:0] pc, input logic [31:0] ins,
                      input bit rd, input bit fl, output bit acc, output logic [63:0] pc_seen);
    int   sz;
    bit   byp;
    ent_t head;
    bus.valid_F     = vf;
    bus.imem_addr_F = pc;
    bus.instr_F     = ins;
    bus.ready_D     = rd;
    bus.flush       = fl;
    #1;
    sz   = q.size();
    byp  = BYP && (sz == 0) && vf && !fl;
    head = '0;
    if (sz != 0) head = q[0];
    else if (byp) head = '{pc: pc, instr: ins};
    pc_seen = bus.pc_D;
    chk("ready_F", bus.ready_F, sz != DEPTH);
    chk("count",   bus.count, sz);
    chk("valid_D", bus.valid_D, (sz != 0) || byp);
    chk("pc_D",    bus.pc_D, head.pc);
    chk("instr_D", bus.instr_D, head.instr);
    @(posedge clk);
    acc = 1'b0;
    if (fl) begin
      q.delete();
    end else if (byp && rd) begin
      acc = 1'b1;
    end else begin
      if (sz != 0 && rd) void'(q.pop_front());
      if (vf && sz != DEPTH) begin
        q.push_back('{pc: pc, instr: ins});
        acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  bit          acc;
  logic [63:0] seen;
  logic [63:0] nxt_pc;

  initial begin
    bus.valid_F = 1'b0; bus.imem_addr_F = '0; bus.instr_F = '0;
    bus.ready_D = 1'b0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid_D", bus.valid_D, 0);
    chk("rst_ready_F", bus.ready_F, 1);
    chk("rst_count",   bus.count, 0);
    chk("rst_pc_D",    bus.pc_D, 0);
    reset = 1'b1;

    // Fill to full, then a rejected fifth push
    for (int i = 0; i < 4; i++) step(1'b1, 64'(4 * i), $urandom, 1'b0, 1'b0, acc, seen);
    chk("full_count", bus.count, 4);
    step(1'b1, 64'd16, $urandom, 1'b0, 1'b0, acc, seen);
    chk("full_pc_D", seen, 0);

    // Drain while fetch holds its PC until accepted
    nxt_pc = 64'd16;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, nxt_pc, $urandom, 1'b1, 1'b0, acc, seen);
      chk("drain_seq", seen, 64'(4 * i));
      if (acc) nxt_pc = nxt_pc + 4;
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) step(1'b0, 0, 0, 1'b1, 1'b0, acc, seen);

    // Flush with a simultaneous push
    for (int i = 0; i < 3; i++) step(1'b1, 64'(100 + 4 * i), $urandom, 1'b0, 1'b0, acc, seen);
    step(1'b1, 64'd457515, $urandom, 1'b0, 1'b1, acc, seen);
    chk("flush_count", bus.count, 0);
    chk("flush_valid", bus.valid_D, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1, 1'b0, acc, seen);

    // Steady push+pop at count 2
    for (int i = 0; i < 2; i++) step(1'b1, 64'(200 + 4 * i), $urandom, 1'b0, 1'b0, acc, seen);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 64'(208 + 4 * i), $urandom, 1'b1, 1'b0, acc, seen);
      chk("pp_count", bus.count, 2);
    end

    // Asynchronous reset mid-stream with 3 entries
    step(1'b1, 64'd500, $urandom, 1'b0, 1'b0, acc, seen);
    bus.valid_F = 1'b0; bus.ready_D = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid_D", bus.valid_D, 0);
    chk("arst_count",   bus.count, 0);
    chk("arst_ready_F", bus.ready_F, 1);
    chk("arst_pc_D",    bus.pc_D, 0);
    q.delete();
    @(negedge clk);
    reset = 1'b1;

    // Empty-queue pass-through (or one-cycle latency without bypass)
    step(1'b1, 64'd40, 32'h1234_5678, 1'b1, 1'b0, acc, seen);
    chk("byp_same_cycle", seen, BYP ? 64'd40 : 64'd0);
    step(1'b0, 0, 0, 1'b1, 1'b0, acc, seen);
    chk("byp_next_cycle", seen, BYP ? 64'd0 : 64'd40);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), 64'($urandom), $urandom,
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0), acc, seen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and decode, replacing the plain IF/ID pipeline register. Each cycle it accepts the fetched PC (`imem_addr_F`) and instruction word from instruction memory and buffers up to DEPTH entries in program order. It presents the oldest entry to decode with a valid/ready handshake. It discards all contents when a taken branch (`PCSrc`) redirects fetch.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2
- AW, 64, PC width
- IW, 32, instruction width

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- imem_addr_F  in  AW  PC of the fetched instruction
- instr_F  in  IW  instruction word read from imem at imem_addr_F
- valid_F  in  1  fetch presents an entry
- ready_F  out  1  queue can accept an entry (not full)
- flush  in  1  taken-branch redirect (PCSrc); discards all entries
- pc_D  out  AW  PC of the head entry
- instr_D  out  IW  instruction of the head entry
- valid_D  out  1  head entry is valid
- ready_D  in  1  decode consumes the head entry
- count  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Push: occurs when valid_F && ready_F. The {imem_addr_F, instr_F} pair is written at the write pointer (wr_ptr), and wr_ptr increments.
- Pop: occurs when valid_D && ready_D. The read pointer (rd_ptr) increments.
- Push and pop in the same cycle:
  - count is unchanged.
  - When count==DEPTH, ready_F=0, so only the pop happens; there is no pass-through on full.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- count ranges from 0 to DEPTH and never overflows or underflows.
- ready_F = (count != DEPTH).
- valid_D = (count != 0), plus the bypass case defined under Configuration.
- pc_D and instr_D show the entry at rd_ptr. They are 0 when count==0 and bypass is inactive.
- Flush has the highest priority. On the next edge:
  - count, wr_ptr and rd_ptr return to 0.
  - Any push or pop in the flush cycle is ignored. The entry offered that cycle is dropped, and decode must treat a handshake in that cycle as void.
- Reset (reset==0), applied asynchronously at any time including mid-operation:
  - count, wr_ptr and rd_ptr are 0; storage is cleared to 0.
  - valid_D=0, ready_F=1, pc_D=0, instr_D=0, count=0.
- Order is preserved: entries reach decode strictly in push order, with no duplicates or losses except on flush.

## Timing
- Without bypass, an entry pushed at edge N is visible on pc_D/instr_D/valid_D after edge N (latency 1 cycle).
- Throughput is 1 entry/cycle sustained when ready_D is held at 1.
- ready_F and count are derived only from registered state; there is no combinational path from ready_D to ready_F.
- The flush effect is visible after the next edge: valid_D=0 and count=0.
- After reset is released, the first push is accepted on the first edge with valid_F=1.

## Configuration
- IFQ_BYPASS_EN defined:
  - When count==0 and valid_F==1 and flush==0, the input passes combinationally to pc_D/instr_D with valid_D=1.
  - If ready_D==1 in that cycle, the entry is consumed, is not written, and count stays 0.
  - If ready_D==0, the entry is written normally.
  - This gives 0-cycle latency when the queue is empty.
- IFQ_BYPASS_EN undefined: bypass logic is absent and latency is always 1 cycle. In this configuration valid_D, pc_D and instr_D depend only on registered state.

## Structure
- Package ifq_pkg holds:
  - the constants IFQ_DEPTH=4, IFQ_AW=64, IFQ_IW=32;
  - typedef struct packed {logic [AW-1:0] pc; logic [IW-1:0] instr;} ifq_entry_t.
- Storage is one sub-module, ifq_mem: a DEPTH×ifq_entry_t register array with one synchronous write port, one asynchronous read port, and asynchronous active-low clear.
- Pointer, count and handshake logic live in if_id_queue.

## Test plan
- Reset, then push PCs 0,4,8,12 with ready_D=0 → count=4, ready_F=0 after the 4th edge; a 5th push of 16 is not accepted; pc_D=0.
- Full queue; ready_D=1 and valid_F=1 for 6 cycles with PCs 16,20,… → pc_D sequence 0,4,8,12,16,20; wrap-around is correct and no entry is lost.
- Queue holds 3 entries; flush=1 for one cycle with a simultaneous push of PC 457515 → next cycle count=0, valid_D=0; PC 457515 never appears at decode.
- Simultaneous push and pop at count=2 for 10 cycles → count stays 2; output order matches input order.
- Assert reset=0 mid-stream with count=3 → immediately valid_D=0, count=0, ready_F=1, pc_D=0 before the next clock edge.
- With IFQ_BYPASS_EN, empty queue, valid_F=1, PC=40, ready_D=1 → pc_D=40 in the same cycle, count stays 0; without the macro, pc_D=40 appears one cycle later.
